hellonios_cpu_debug_ocimem_ctrl: RTL and testbench

On-chip debug memory controller for the Nios II debug module. It sits directly downstream of the CPU debug-slave wrapper and consumes that block's clk-domain outputs `jdo`, `take_action_ocimem_a`, `take_action_ocimem_b` and `take_no_action_ocimem_a`. It owns a 2**ADDR_W x 32 monitor RAM and arbitrates JTAG-host accesses against CPU Avalon debug-slave accesses. It returns read data to the JTAG chain through `MonDReg`.

---
 rtl/hellonios_cpu_debug_ocimem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hellonios_cpu_debug_ocimem_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hellonios_cpu_debug_ocimem_ctrl.sv
// Debug monitor RAM controller: arbitrates JTAG-host word accesses against
// CPU Avalon debug-slave accesses to a single-port 2**ADDR_W x 32 RAM.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | arbitration; pending JTAG op beats the CPU
// ST_JRD  | JTAG read data returning, captured into MonDReg
// ST_CRD  | CPU read data returning on readdata
module hellonios_cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic              debugaccess,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JRD  = 2'd1,
        ST_CRD  = 2'd2
    } state_t;

    state_t            state;
    logic              pend;
    logic              pend_wr;
    logic [31:0]       pend_data;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;

    logic              st_idle;
    logic              st_jrd;
    logic              st_crd;
    logic              jtag_svc;
    logic              cpu_svc;
    logic              cpu_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_re;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;

    logic              op_valid;
    logic              op_wr;
    logic              op_low_drop;
    logic              op_drop;
    logic              op_accept;
    logic              unused_jdo;

    assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

    assign st_idle  = (state == ST_IDLE);
    assign st_jrd   = (state == ST_JRD);
    assign st_crd   = (state == ST_CRD);
    assign jtag_svc = st_idle & pend;
    assign cpu_svc  = st_idle & ~pend;
    assign cpu_rd   = chipselect & read & ~write;

    assign ram_addr  = jtag_svc ? MonAReg : address;
    assign ram_be    = jtag_svc ? 4'hF : byteenable;
    assign ram_wdata = jtag_svc ? pend_data : writedata;
    assign ram_we    = jtag_svc ? pend_wr
                                : (cpu_svc & chipselect & write & debugaccess);
    assign ram_re    = jtag_svc ? ~pend_wr : (cpu_svc & cpu_rd);

    assign readdata    = ram_q;
    assign waitrequest = chipselect & (read | write) & ~(cpu_svc & write) & ~st_crd;
    assign jtag_busy   = pend | st_jrd;

    // Only the highest-priority pulse is acted on; any lower one is a lost RAM op.
    always_comb begin
        op_valid    = 1'b0;
        op_wr       = 1'b0;
        op_low_drop = 1'b0;
        if (take_action_ocimem_a) begin
            op_valid    = jdo[35];
            op_low_drop = take_action_ocimem_b | take_no_action_ocimem_a;
        end else if (take_action_ocimem_b) begin
            op_valid    = 1'b1;
            op_wr       = 1'b1;
            op_low_drop = take_no_action_ocimem_a;
        end else if (take_no_action_ocimem_a) begin
            op_valid    = 1'b1;
        end
    end

    assign op_drop   = op_valid & (pend | (~op_wr & st_jrd));
    assign op_accept = op_valid & ~op_drop;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_q <= '0;
        end else if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            pend         <= 1'b0;
            pend_wr      <= 1'b0;
            pend_data    <= '0;
            MonDReg      <= '0;
            MonAReg      <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (jtag_svc) pend <= 1'b0;
            if (op_accept) begin
                pend      <= 1'b1;
                pend_wr   <= op_wr;
                pend_data <= jdo[34:3];
            end

            // An address load overrides any auto-increment at the same edge.
            if (take_action_ocimem_a) begin
                MonAReg <= jdo[ADDR_W+9:10];
            end else if ((jtag_svc & pend_wr) | st_jrd) begin
                MonAReg <= MonAReg + ADDR_W'(1);
            end

            if (op_drop | op_low_drop) begin
                jtag_overrun <= 1'b1;
            end else if (take_action_ocimem_a) begin
                jtag_overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (jtag_svc) begin
                        if (!pend_wr) state <= ST_JRD;
                    end else if (cpu_rd) begin
                        state <= ST_CRD;
                    end
                end
                ST_JRD: begin
                    MonDReg <= ram_q;
                    state   <= ST_IDLE;
                end
                ST_CRD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hellonios_cpu_debug_ocimem_ctrl.sv
// Directed plus randomized bench for the debug monitor RAM controller,
// checked against an array-based model of RAM, JTAG address and overrun flag.
module tb_hellonios_cpu_debug_ocimem_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic        debugaccess;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jtag_busy;
    logic        jtag_overrun;

    hellonios_cpu_debug_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .address                 (address),
        .chipselect              (chipselect),
        .read                    (read),
        .write                   (write),
        .debugaccess             (debugaccess),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mm [256];
    logic [7:0]  ma;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j        = '0;
        j[35]    = rd;
        j[17:10] = a;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic jtag_load(input logic [7:0] a, input logic rd);
        @(negedge clk);
        jdo = mk_a(a, rd);
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        ma = a;
        check("load_addr", 32'(MonAReg), 32'(ma));
        check("load_ovr_clr", 32'(jtag_overrun), 32'(0));
        if (rd) begin
            check("load_busy", 32'(jtag_busy), 32'(1));
            @(negedge clk);
            @(negedge clk);
            check("load_rd_data", MonDReg, mm[ma]);
            ma = ma + 8'd1;
            check("load_rd_addr", 32'(MonAReg), 32'(ma));
            check("load_rd_busy", 32'(jtag_busy), 32'(0));
        end
    endtask

    task automatic jtag_write(input logic [31:0] d);
        @(negedge clk);
        jdo = mk_b(d);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        check("wr_busy", 32'(jtag_busy), 32'(1));
        @(negedge clk);
        mm[ma] = d;
        ma = ma + 8'd1;
        check("wr_addr", 32'(MonAReg), 32'(ma));
        check("wr_idle", 32'(jtag_busy), 32'(0));
    endtask

    task automatic jtag_read();
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        check("rd_busy", 32'(jtag_busy), 32'(1));
        @(negedge clk);
        @(negedge clk);
        check("rd_data", MonDReg, mm[ma]);
        ma = ma + 8'd1;
        check("rd_addr", 32'(MonAReg), 32'(ma));
        check("rd_idle", 32'(jtag_busy), 32'(0));
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic dbg);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a;
        writedata = d; byteenable = be; debugaccess = dbg;
        #1;
        check("cpu_wr_wait", 32'(waitrequest), 32'(0));
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        if (dbg) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mm[a][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    // Holds the read under waitrequest and counts cycles until it completes.
    task automatic cpu_hold_read(input string tag, input logic [7:0] a, input int exp_waits);
        int waits;
        waits = 0;
        while (waitrequest && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        check({tag, "_data"}, readdata, mm[a]);
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a; debugaccess = 1'b1;
        #1;
        check("cpu_rd_issue", 32'(waitrequest), 32'(1));
        cpu_hold_read("cpu_rd", a, 1);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd32;
        logic [3:0]  rbe;
        logic [31:0] vx;
        logic [31:0] vy;
        logic [7:0]  ovr_addr;

        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        debugaccess = 1'b0; writedata = '0; byteenable = '0;
        ma = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_monareg", 32'(MonAReg), 32'h0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_overrun", 32'(jtag_overrun), 32'h0);
        check("rst_busy", 32'(jtag_busy), 32'h0);
        check("rst_wait", 32'(waitrequest), 32'h0);

        // Fill the whole RAM so every later readback has a known value; ends wrapped at 0.
        jtag_load(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) jtag_write($urandom);
        check("fill_wrap", 32'(MonAReg), 32'h0);

        jtag_load(8'h10, 1'b0);
        jtag_write(32'hA1);
        jtag_write(32'hA2);
        jtag_write(32'hA3);
        check("seq_addr", 32'(MonAReg), 32'h13);
        jtag_load(8'h10, 1'b1);
        check("readback_a1", MonDReg, 32'hA1);
        jtag_read();
        check("readback_a2", MonDReg, 32'hA2);
        check("readback_addr", 32'(MonAReg), 32'h12);

        jtag_load(8'hFF, 1'b0);
        jtag_write(32'hDEADBEEF);
        check("wrap_addr", 32'(MonAReg), 32'h00);
        jtag_read();
        jtag_load(8'hFF, 1'b1);
        check("wrap_data", MonDReg, 32'hDEADBEEF);

        // CPU read raised while a JTAG write to the same word is pending.
        jtag_load(8'h10, 1'b0);
        @(negedge clk);
        jdo = mk_b(32'h55);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        chipselect = 1'b1; read = 1'b1; address = 8'h10; debugaccess = 1'b1;
        #1;
        check("cont_busy", 32'(jtag_busy), 32'(1));
        check("cont_wait", 32'(waitrequest), 32'(1));
        mm[8'h10] = 32'h55;
        ma = ma + 8'd1;
        cpu_hold_read("cont", 8'h10, 2);
        check("cont_addr", 32'(MonAReg), 32'h11);

        cpu_write(8'h20, 32'h0000AB00, 4'b0010, 1'b1);
        cpu_read(8'h20);
        cpu_write(8'h20, 32'h12345678, 4'b1111, 1'b0);
        cpu_read(8'h20);
        jtag_load(8'h20, 1'b1);

        for (int n = 0; n < 300; n++) begin
            ra = 8'($urandom);
            rd32 = $urandom;
            rbe = 4'($urandom);
            case ($urandom_range(0, 4))
                0: jtag_load(ra, 1'($urandom_range(0, 1)));
                1: jtag_write(rd32);
                2: jtag_read();
                3: cpu_write(ra, rd32, rbe, 1'($urandom_range(0, 1)));
                default: cpu_read(ra);
            endcase
        end

        // Two back-to-back ocimem_b pulses, the first sampled during CRD.
        ra = 8'($urandom);
        vx = $urandom;
        vy = ~vx;
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = ra; debugaccess = 1'b1;
        #1;
        check("ovr_issue", 32'(waitrequest), 32'(1));
        @(negedge clk);
        check("ovr_crd_wait", 32'(waitrequest), 32'(0));
        check("ovr_crd_data", readdata, mm[ra]);
        chipselect = 1'b0; read = 1'b0;
        jdo = mk_b(vx);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        check("ovr_pend", 32'(jtag_busy), 32'(1));
        jdo = mk_b(vy);
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        ovr_addr = ma;
        mm[ma] = vx;
        ma = ma + 8'd1;
        check("ovr_set", 32'(jtag_overrun), 32'(1));
        check("ovr_addr", 32'(MonAReg), 32'(ma));
        cpu_read(ovr_addr);
        check("ovr_sticky", 32'(jtag_overrun), 32'(1));
        jtag_load(ovr_addr, 1'b1);
        check("ovr_first_kept", MonDReg, vx);

        // Reset asserted while a JTAG read is in JRD.
        @(negedge clk);
        jdo = mk_a(8'h33, 1'b1);
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        @(negedge clk);
        check("jrd_busy", 32'(jtag_busy), 32'(1));
        reset_n = 1'b0;
        #1;
        check("arst_mondreg", MonDReg, 32'h0);
        check("arst_monareg", 32'(MonAReg), 32'h0);
        check("arst_busy", 32'(jtag_busy), 32'h0);
        check("arst_readdata", readdata, 32'h0);
        check("arst_overrun", 32'(jtag_overrun), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        ma = '0;
        repeat (3) @(negedge clk);
        check("post_rst_mondreg", MonDReg, 32'h0);
        check("post_rst_busy", 32'(jtag_busy), 32'h0);
        jtag_read();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
